ws2812_frame_ctrl: RTL

WS2812_FRAME_CTRL -- requirements
Module: ws2812_frame_ctrl

---
 rtl/ws2812_pkg.sv | 28 ++
 rtl/ws2812_frame_ctrl_if.sv | 27 ++
 rtl/ws2812_rr_arb2.sv | 26 ++
 rtl/ws2812_frame_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Timing constants shared by the WS2812 bit driver and the frame controller.
// Derived from the LED protocol at a given clock rate in MHz.
package ws2812_pkg;

  localparam int RGB_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SWAP = 2'd2
  } frame_state_e;

  // One bit slot is 1.25 us, rounded up to whole clocks.
  function automatic int t_period(input int clk_mhz);
    return (clk_mhz * 1250 + 999) / 1000;
  endfunction

  // Latch/reset gap of 280 us.
  function automatic int t_reset(input int clk_mhz);
    return clk_mhz * 280;
  endfunction

  // One reset gap plus a full frame, with one extra LED slot of margin.
  function automatic int holdoff_default(input int clk_mhz, input int num_leds);
    return t_reset(clk_mhz) + 1 + RGB_W * (num_leds + 1) * (t_period(clk_mhz) + 1);
  endfunction

endpackage

// File: rtl/ws2812_frame_ctrl_if.sv
// Two independent pixel-write requesters feeding the frame controller.
interface ws2812_frame_ctrl_if #(
  parameter int AW = 3
);
  logic          wr0_valid;
  logic [AW-1:0] wr0_addr;
  logic [23:0]   wr0_rgb;
  logic          wr0_ready;
  logic          wr1_valid;
  logic [AW-1:0] wr1_addr;
  logic [23:0]   wr1_rgb;
  logic          wr1_ready;

  modport master (
    output wr0_valid, wr0_addr, wr0_rgb,
    input  wr0_ready,
    output wr1_valid, wr1_addr, wr1_rgb,
    input  wr1_ready
  );

  modport slave (
    input  wr0_valid, wr0_addr, wr0_rgb,
    output wr0_ready,
    input  wr1_valid, wr1_addr, wr1_rgb,
    output wr1_ready
  );
endinterface

// File: rtl/ws2812_rr_arb2.sv
// Two-way round-robin arbiter; priority flips to the other side after a grant is used.
module ws2812_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic prio_q, prio_d;

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || !prio_q)) grant = 2'b01;
    else if (req[1])                    grant = 2'b10;
  end

  always_comb begin
    prio_d = prio_q;
    if (advance) prio_d = grant[0];
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end
endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Double-buffered WS2812 frame store: writers fill a shadow frame, a commit
// publishes it atomically to the active frame, rate-limited by a holdoff counter.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int CLK_MHZ  = 12,
  parameter int HOLDOFF  = holdoff_default(CLK_MHZ, NUM_LEDS),
  localparam int AW      = ($clog2(NUM_LEDS) > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  ws2812_frame_ctrl_if.slave        wr,
  input  logic                      commit,
  output logic                      commit_done,
  output logic                      busy,
  output logic [RGB_W*NUM_LEDS-1:0] packed_rgb_data,
  output logic                      drv_reset
);
  localparam int CW = $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);

  frame_state_e              state_q, state_d;
  logic [CW-1:0]             hold_q, hold_d;
  logic [RGB_W*NUM_LEDS-1:0] shadow_q, shadow_d;
  logic [RGB_W*NUM_LEDS-1:0] active_q, active_d;
  logic [1:0]                grant;
  logic                      advance;
  logic [AW-1:0]             wr_addr;
  logic [RGB_W-1:0]          wr_rgb;

  ws2812_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (reset),
    .req     ({wr.wr1_valid, wr.wr0_valid}),
    .advance (advance),
    .grant   (grant)
  );

  assign wr.wr0_ready = grant[0] && (state_q != SWAP);
  assign wr.wr1_ready = grant[1] && (state_q != SWAP);
  assign advance      = wr.wr0_ready || wr.wr1_ready;
  assign wr_addr      = grant[1] ? wr.wr1_addr : wr.wr0_addr;
  assign wr_rgb       = grant[1] ? wr.wr1_rgb  : wr.wr0_rgb;

  // Out-of-range addresses match no slot, so they are accepted and dropped.
  always_comb begin
    shadow_d = shadow_q;
    for (int n = 0; n < NUM_LEDS; n++) begin
      if (advance && (int'(wr_addr) == n)) shadow_d[RGB_W*n +: RGB_W] = wr_rgb;
    end
  end

  // Counter is loaded on entry to SWAP so successive SWAPs are exactly HOLDOFF apart.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    active_d = active_q;
    if (hold_q != '0) hold_d = hold_q - CW'(1);
    case (state_q)
      IDLE: if (commit) state_d = PEND;
      PEND: begin
        if (hold_q == '0) begin
          state_d = SWAP;
          hold_d  = HOLD_LOAD;
        end
      end
      SWAP: begin
        state_d  = IDLE;
        active_d = shadow_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign commit_done     = (state_q == SWAP) && !reset;
  assign drv_reset       = reset || (state_q == SWAP);
  assign busy            = (state_q != IDLE);
  assign packed_rgb_data = active_q;
endmodule
